// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions: link state codes, widths, helpers.
package tl_pkg;

  localparam int DATA_W    = 12;
  localparam int SRC_IDX_W = 2;

  // Link state is one-hot; any other code is treated as "no new work".
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } link_state_e;

  // Encode a one-hot 4-bit vector into its index (0 when no bit is set).
  function automatic logic [SRC_IDX_W-1:0] onehot2idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// Source-FIFO / downstream-FIFO signal bundle seen by the VC pop arbiter.
interface vc_pop_arbiter_if
  import tl_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC-1:0]        src_empty;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      dst_almost_full;
  logic [NUM_SRC-1:0]        src_pop;
  logic                      dst_push;
  logic [DATA_W-1:0]         dst_data;
  logic [SRC_IDX_W-1:0]      dst_tag;
  logic [CNT_W-1:0]          xfer_count;

  // Arbiter side.
  modport master (
    input  src_empty, src_data, dst_almost_full,
    output src_pop, dst_push, dst_data, dst_tag, xfer_count
  );

  // FIFO side.
  modport slave (
    output src_empty, src_data, dst_almost_full,
    input  src_pop, dst_push, dst_data, dst_tag, xfer_count
  );
endinterface

// File: rtl/rr_grant4.sv
// Combinational 4-way round-robin picker: first requester after last_grant.
module rr_grant4
  import tl_pkg::*;
(
  input  logic [3:0]           req,
  input  logic [SRC_IDX_W-1:0] last_grant,
  output logic                 grant_valid,
  output logic [SRC_IDX_W-1:0] grant_idx
);

  logic [SRC_IDX_W-1:0] cand;

  // Walk last_grant+1 .. last_grant+4 (mod 4); last_grant itself is tried last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + SRC_IDX_W'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Drains the VC source FIFOs round-robin into one downstream FIFO, tagging
// each word with its source index. Pop -> capture -> push is 2 cycles.
module vc_pop_arbiter
  import tl_pkg::*;
#(
  parameter int DATA_W  = tl_pkg::DATA_W,
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  vc_pop_arbiter_if.master bus
);

  logic [NUM_SRC-1:0]   src_pop_q,    src_pop_d;
  logic                 dst_push_q,   dst_push_d;
  logic [DATA_W-1:0]    dst_data_q,   dst_data_d;
  logic [SRC_IDX_W-1:0] dst_tag_q,    dst_tag_d;
  logic [CNT_W-1:0]     xfer_q,       xfer_d;
  logic [SRC_IDX_W-1:0] last_grant_q, last_grant_d;
  logic                 pend_q,       pend_d;
  logic [SRC_IDX_W-1:0] pend_idx_q,   pend_idx_d;

  logic                 arb_en;
  logic [3:0]           req;
  logic                 grant_valid;
  logic [SRC_IDX_W-1:0] grant_idx;

  // Only idle/active may start pops. The source popped last cycle is masked
  // because its empty flag has not yet caught up with that pop.
  assign arb_en = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign req    = ~bus.src_empty & ~src_pop_q
                & {NUM_SRC{arb_en & ~bus.dst_almost_full}};

  rr_grant4 u_rr (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state: grant -> pop, pop -> pend (word appears), pend -> push.
  always_comb begin
    src_pop_d    = '0;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      src_pop_d[grant_idx] = 1'b1;
      last_grant_d         = grant_idx;
    end
    pend_d     = |src_pop_q;
    pend_idx_d = (|src_pop_q) ? onehot2idx(src_pop_q) : pend_idx_q;
    dst_push_d = pend_q;
    dst_data_d = pend_q ? bus.src_data[pend_idx_q*DATA_W +: DATA_W] : dst_data_q;
    dst_tag_d  = pend_q ? pend_idx_q : dst_tag_q;
    xfer_d     = xfer_q + CNT_W'(dst_push_q);

    if (state == ST_RESET) begin
      src_pop_d    = '0;
      dst_push_d   = 1'b0;
      dst_data_d   = '0;
      dst_tag_d    = '0;
      xfer_d       = '0;
      last_grant_d = 2'd3;
      pend_d       = 1'b0;
      pend_idx_d   = '0;
    end else if (state == ST_INIT) begin
      // In-flight words are dropped; captured data/tag simply hold.
      src_pop_d    = '0;
      dst_push_d   = 1'b0;
      xfer_d       = '0;
      last_grant_d = 2'd3;
      pend_d       = 1'b0;
    end
  end

  // State registers; last_grant resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_pop_q    <= '0;
      dst_push_q   <= 1'b0;
      dst_data_q   <= '0;
      dst_tag_q    <= '0;
      xfer_q       <= '0;
      last_grant_q <= 2'd3;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
    end else begin
      src_pop_q    <= src_pop_d;
      dst_push_q   <= dst_push_d;
      dst_data_q   <= dst_data_d;
      dst_tag_q    <= dst_tag_d;
      xfer_q       <= xfer_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
    end
  end

  assign bus.src_pop    = src_pop_q;
  assign bus.dst_push   = dst_push_q;
  assign bus.dst_data   = dst_data_q;
  assign bus.dst_tag    = dst_tag_q;
  assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench: source FIFOs modelled as queues with registered empty/data.
module tb_vc_pop_arbiter;
  import tl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = ST_ACTIVE;

  vc_pop_arbiter_if #(.DATA_W(12), .NUM_SRC(4), .CNT_W(8)) bus ();

  vc_pop_arbiter #(.DATA_W(12), .NUM_SRC(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .state (state),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Source FIFO model.
  logic [11:0] q [4][$];
  logic [3:0]  se;
  logic [11:0] sd [4];
  int          underflow;
  int          cyc;

  assign bus.src_empty = se;
  always_comb for (int i = 0; i < 4; i++) bus.src_data[i*12 +: 12] = sd[i];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        sd[i] <= '0;
        q[i].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.src_pop[i]) begin
          if (q[i].size() == 0) underflow <= underflow + 1;
          else sd[i] <= q[i].pop_front();
        end
        se[i] <= (q[i].size() == 0);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event logs sampled mid-cycle.
  logic [3:0]  pop_log [$];
  int          pop_cyc [$];
  logic [1:0]  push_tag [$];
  logic [11:0] push_dat [$];
  int          push_cyc [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.src_pop != 4'b0000) begin
        pop_log.push_back(bus.src_pop);
        pop_cyc.push_back(cyc);
      end
      if (bus.dst_push) begin
        push_tag.push_back(bus.dst_tag);
        push_dat.push_back(bus.dst_data);
        push_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete();
    push_tag.delete(); push_dat.delete(); push_cyc.delete();
  endtask

  task automatic init_pulse();
    state = ST_INIT;
    step();
    state = ST_ACTIVE;
  endtask

  task automatic wait_pop(output logic [3:0] pv);
    pv = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.src_pop != 4'b0000) begin
        pv = bus.src_pop;
        break;
      end
    end
    if (pv == 4'b0000) chk("wait_pop_timeout", 0, 1);
  endtask

  logic [3:0] pv;

  initial begin
    underflow = 0;
    cyc = 0;
    bus.dst_almost_full = 1'b0;
    run(2);
    rst_n = 1'b1;
    step();

    // T1: async reset while popping, then restart from source 0.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) q[i].push_back(12'((i + 1) << 8 | k));
    wait_pop(pv);
    chk("t1_pre_pop", pv, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_pop",  bus.src_pop, 0);
    chk("t1_rst_push", bus.dst_push, 0);
    chk("t1_rst_data", bus.dst_data, 0);
    chk("t1_rst_tag",  bus.dst_tag, 0);
    chk("t1_rst_cnt",  bus.xfer_count, 0);
    run(2);
    rst_n = 1'b1;
    q[0].push_back(12'h0A1);
    clear_logs();
    run(8);
    chk("t1_npop",  pop_log.size(), 1);
    chk("t1_pop0",  pop_log[0], 4'b0001);
    chk("t1_npush", push_tag.size(), 1);
    chk("t1_data",  push_dat[0], 12'h0A1);
    chk("t1_lat",   push_cyc[0] - pop_cyc[0], 2);
    chk("t1_cnt",   bus.xfer_count, 1);

    // T2: all sources busy -> strict rotation, one push per cycle.
    init_pulse();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) q[i].push_back(12'((i + 1) << 8 | k));
    clear_logs();
    run(20);
    chk("t2_npop", pop_log.size(), 8);
    chk("t2_p0", pop_log[0], 4'b0001);
    chk("t2_p1", pop_log[1], 4'b0010);
    chk("t2_p2", pop_log[2], 4'b0100);
    chk("t2_p3", pop_log[3], 4'b1000);
    chk("t2_p4", pop_log[4], 4'b0001);
    chk("t2_b2b", pop_cyc[4] - pop_cyc[0], 4);
    chk("t2_npush", push_tag.size(), 8);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_tag%0d", k), push_tag[k], k);
      chk($sformatf("t2_dat%0d", k), push_dat[k], (k + 1) << 8);
    end
    chk("t2_lat",  push_cyc[0] - pop_cyc[0], 2);
    chk("t2_cnt",  bus.xfer_count, 8);
    chk("t2_hold_data", bus.dst_data, 12'h401);
    chk("t2_hold_tag",  bus.dst_tag, 3);
    chk("t2_idle_push", bus.dst_push, 0);

    // T3: single word in source 2; stale empty must not cause a second pop.
    init_pulse();
    q[2].push_back(12'hABC);
    clear_logs();
    run(10);
    chk("t3_npop",  pop_log.size(), 1);
    chk("t3_pop",   pop_log[0], 4'b0100);
    chk("t3_npush", push_tag.size(), 1);
    chk("t3_data",  push_dat[0], 12'hABC);
    chk("t3_tag",   push_tag[0], 2);
    chk("t3_cnt",   bus.xfer_count, 1);
    chk("t3_under", underflow, 0);

    // T4: almost_full blocks new grants; in-flight words still land.
    init_pulse();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) q[i].push_back(12'((i + 1) << 8 | k));
    wait_pop(pv);
    chk("t4_pop0", pv, 4'b0001);
    step();
    chk("t4_pop1", bus.src_pop, 4'b0010);
    bus.dst_almost_full = 1'b1;
    clear_logs();
    run(6);
    chk("t4_af_npop",  pop_log.size(), 0);
    chk("t4_af_npush", push_tag.size(), 2);
    chk("t4_af_tag0",  push_tag[0], 0);
    chk("t4_af_tag1",  push_tag[1], 1);
    bus.dst_almost_full = 1'b0;
    step();
    chk("t4_resume", bus.src_pop, 4'b0100);
    run(30);
    chk("t4_cnt",   bus.xfer_count, 16);
    chk("t4_under", underflow, 0);

    // T5: 256 pushes wrap the counter; init clears it and the RR pointer.
    init_pulse();
    for (int k = 0; k < 128; k++) begin
      q[0].push_back(12'(k));
      q[1].push_back(12'(12'h800 | k));
    end
    clear_logs();
    run(270);
    chk("t5_npush", push_tag.size(), 256);
    chk("t5_wrap",  bus.xfer_count, 0);
    q[0].push_back(12'h055);
    run(8);
    chk("t5_cnt1", bus.xfer_count, 1);
    init_pulse();
    chk("t5_init_cnt", bus.xfer_count, 0);
    for (int i = 0; i < 4; i++) q[i].push_back(12'h0F0 | 12'(i));
    wait_pop(pv);
    chk("t5_init_rr", pv, 4'b0001);
    run(15);

    // T6: idle arbitrates; unknown code stops new pops but finishes pend.
    init_pulse();
    state = ST_IDLE;
    q[3].push_back(12'h3A0);
    q[3].push_back(12'h3A1);
    wait_pop(pv);
    chk("t6_idle_pop", pv, 4'b1000);
    state = 4'b1111;
    clear_logs();
    run(6);
    chk("t6_npop",  pop_log.size(), 0);
    chk("t6_npush", push_tag.size(), 1);
    chk("t6_tag",   push_tag[0], 3);
    chk("t6_data",  push_dat[0], 12'h3A0);
    state = ST_ACTIVE;
    run(10);
    chk("t6_cnt", bus.xfer_count, 2);

    // T7: synchronous soft reset via link state.
    state = ST_RESET;
    step();
    chk("t7_cnt",  bus.xfer_count, 0);
    chk("t7_data", bus.dst_data, 0);
    chk("t7_tag",  bus.dst_tag, 0);
    chk("t7_pop",  bus.src_pop, 0);
    state = ST_ACTIVE;
    run(2);

    chk("end_under", underflow, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // One pop per cycle at most, checked continuously.
  always @(negedge clk) if (rst_n) chk("pop_onehot", 32'($onehot0(bus.src_pop)), 1);

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Drain-side controller for the transaction-layer virtual-channel FIFOs.
- Watches NUM_SRC source FIFOs and pops them round-robin, one word per grant.
- Captures each popped word and pushes it, with its source index, into the single downstream FIFO.
- Honours the shared link state code and downstream almost-full backpressure.

Parameters:
DATA_W, 12, width of FIFO words
NUM_SRC, 4, number of source FIFOs (fixed at 4; index is 2 bits)
CNT_W, 8, width of the transferred-word counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
state  input  4  link state code: 0001 reset, 0010 init, 0100 idle, 1000 active
src_empty  input  NUM_SRC  exact empty flag per source FIFO (registered in source)
src_data  input  NUM_SRC*DATA_W  source data_out buses, source i at bits [i*DATA_W +: DATA_W]
dst_almost_full  input  1  downstream FIFO almost_full
src_pop  output  NUM_SRC  one-hot pop strobe to source FIFOs
dst_push  output  1  push strobe to downstream FIFO
dst_data  output  DATA_W  word pushed downstream
dst_tag  output  2  source index of dst_data
xfer_count  output  CNT_W  words pushed since reset/init, wraps modulo 2^CNT_W

Behaviour:
- reset low (asynchronous): src_pop=0, dst_push=0, dst_data=0, dst_tag=0, xfer_count=0, last_grant=3, pend=0, pend_idx=0.
- state 0001 (synchronous soft reset): same values as asynchronous reset, loaded at the clock edge.
- state 0010 (init):
  - src_pop=0, dst_push=0, xfer_count cleared, last_grant=3.
  - Any in-flight pend is discarded.
- state 0100 or 1000: arbitration enabled. Any other code behaves as idle: no new pops, but in-flight words still complete.
- Eligibility: source i is eligible in cycle N when src_empty[i]=0, dst_almost_full=0, and i was not granted in cycle N-1. The last condition masks the stale empty flag.
- Grant:
  - Search from (last_grant+1) mod 4 upward, wrapping; take the first eligible source.
  - The grant is registered, so src_pop[i]=1 for exactly the cycle after the decision. Then last_grant<=i.
  - At most one pop bit is high per cycle. src_pop is never asserted on an empty source.
- Latency:
  - src_pop[i] high in cycle P.
  - The source presents the word on src_data[i] in cycle P+1; pend/pend_idx track this.
  - At the P+1 edge the word is captured: dst_data<=src_data[pend_idx], dst_tag<=pend_idx, dst_push=1 during cycle P+2.
  - Pop-to-push latency is 2 cycles. Back-to-back grants to different sources give one push per cycle.
- dst_push is a single-cycle strobe per word. dst_data/dst_tag hold their value when dst_push=0.
- xfer_count increments by 1 on each cycle with dst_push=1; 255 -> 0.
- Backpressure:
  - dst_almost_full only stops new grants; up to 2 in-flight words still push.
  - The downstream umbral_AF must leave at least 2 free entries.
- Single non-empty source: it is granted at most every other cycle (mask rule), so it can never be over-popped.
- Reset asserted mid-transfer: in-flight words are dropped and no push is issued. The source-side pop has already taken effect, which is acceptable because the whole datapath is being reset.

Decomposition:
- Shared package (tl_pkg):
  - state codes ST_RESET=4'b0001, ST_INIT=4'b0010, ST_IDLE=4'b0100, ST_ACTIVE=4'b1000
  - DATA_W=12
  - SRC_IDX_W=2
- One sub-module, rr_grant4: combinational round-robin picker.
  - Inputs: 4-bit request, 2-bit last_grant.
  - Outputs: grant_valid, 2-bit grant_idx.
- Registers, pipeline and counter live in vc_pop_arbiter.

Test Plan:
- Reset low mid-run with src_pop active -> all outputs 0 immediately (asynchronous); after release with state=1000 and src_empty=4'b1110, the first src_pop=4'b0001.
- state=1000, all sources non-empty, dst_almost_full=0 -> src_pop sequence 0001,0010,0100,1000,0001; dst_tag 0,1,2,3 starting 2 cycles after the first pop; xfer_count reaches 4.
- Only source 2 non-empty holding 1 word, src_empty[2] falling 1 cycle after the pop -> exactly one src_pop=0100, one dst_push carrying 12'hABC with tag 2, no second pop.
- dst_almost_full rises in the cycle after a pop -> no further pops; exactly the in-flight words (at most 2) are pushed; pops resume the cycle after it falls.
- Push 256 words -> xfer_count wraps to 0; then state=0010 for 1 cycle -> xfer_count=0, next grant starts at source 0.
- state=0100 with data available -> arbitration proceeds; state=1111 -> no new src_pop, pending word still pushed.
